bus_drive_arbiter: RTL



---
 rtl/bus_drive_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_drive_arbiter.sv
// Bus drive arbiter: grants one requester at a time ownership of the shared
// result/tag bus, producing one-hot tri-state drive enables. Ownership rotates
// round-robin. An owner is preempted after MAX_HOLD cycles when another
// requester is waiting. At least TURN_CYC all-disabled cycles separate any
// release from the next grant, so two drivers never overlap on the bus.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   req          level request per requester
//   last         final-beat flag; only the current owner's bit is used
//   drive_en     one-hot/zero tri-state buffer enables (registered)
//   owner_id     index of the current or most recent owner (registered)
//   bus_busy     high while a requester owns the bus or during turnaround
//   grant_pulse  one-hot pulse during the first owned cycle
module bus_drive_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] drive_en,
  output logic [ID_W-1:0]    owner_id,
  output logic               bus_busy,
  output logic [NUM_REQ-1:0] grant_pulse
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWNED,
    S_TURN
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [NUM_REQ-1:0] drive_en_d, grant_pulse_d;
  logic [ID_W-1:0]    owner_id_d;
  logic               bus_busy_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   cand;
  logic               competitor;
  logic               rel_now;
  logic               grant;

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Release conditions for the current owner; last and hold expiry collapse
  // into one release because they share this single flag.
  always_comb begin
    competitor = |(req & ~(NUM_REQ'(1) << owner_q));
    rel_now    = !req[owner_q] || last[owner_q] ||
                 ((hold_cnt_q == HOLD_W'(MAX_HOLD)) && competitor);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      drive_en    <= '0;
      grant_pulse <= '0;
      owner_id    <= '0;
      bus_busy    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      drive_en    <= drive_en_d;
      grant_pulse <= grant_pulse_d;
      owner_id    <= owner_id_d;
      bus_busy    <= bus_busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    hold_cnt_d    = hold_cnt_q;
    turn_cnt_d    = turn_cnt_q;
    drive_en_d    = drive_en;
    grant_pulse_d = '0;
    owner_id_d    = owner_id;
    bus_busy_d    = bus_busy;
    grant         = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant = sel_found;
      end
      S_OWNED: begin
        if (rel_now) begin
          state_d    = S_TURN;
          drive_en_d = '0;
          // Previous owner drops to lowest priority for the next pick.
          rr_ptr_d   = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + PTR_W'(1);
          turn_cnt_d = TURN_W'(TURN_CYC - 1);
        end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_TURN: begin
        if (turn_cnt_q != '0) begin
          turn_cnt_d = turn_cnt_q - TURN_W'(1);
        end else if (sel_found) begin
          grant = 1'b1;
        end else begin
          state_d    = S_IDLE;
          bus_busy_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (grant) begin
      state_d       = S_OWNED;
      owner_d       = sel_idx;
      drive_en_d    = NUM_REQ'(1) << sel_idx;
      grant_pulse_d = NUM_REQ'(1) << sel_idx;
      owner_id_d    = ID_W'(sel_idx);
      bus_busy_d    = 1'b1;
      hold_cnt_d    = HOLD_W'(1);
    end
  end

endmodule
